adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 req0  in  1  requester 0 operation request, held high until ack0.
REQ-005 a0, b0  in  32 each  requester 0 operands, held stable while req0 high.
REQ-006 sub0  in  1  requester 0 op select: 0 = A+B, 1 = A-B.
REQ-007 req1, a1, b1, sub1  in  1/32/32/1  requester 1 equivalents of REQ-004..006.
REQ-008 ack0, ack1  out  1 each  one-cycle completion pulse to the served requester.
REQ-009 result  out  32  registered sum/difference of the served operation.
REQ-010 carry_out  out  1  registered adder carry; for subtract, 1 = no borrow.
REQ-011 overflow  out  1  registered two's-complement signed overflow.
REQ-012 result_valid  out  1  high exactly in the cycle result/carry_out/overflow/result_id are valid.
REQ-013 result_id  out  1  index of the requester served (0 or 1).
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 Block SHALL contain exactly one instance of the team's 32-bit ripple adder (ports: S, carry_out, A, B, carry_in); all arithmetic SHALL pass through it.
REQ-016 FSM states: IDLE, ADD, DONE; no other states.
REQ-017 IDLE: if no req, stay IDLE; if either req high, latch winner's A, B, sub and id into operand registers, go ADD.
REQ-018 Arbitration: round-robin via 1-bit priority pointer; if both reqs high, requester equal to pointer wins; if one req high, it wins regardless of pointer.
REQ-019 ADD: adder inputs = latched A, (sub ? ~B : B), carry_in = sub; register S, carry, overflow into result regs; go DONE.
REQ-020 overflow = (A[31] == B_eff[31]) && (S[31] != A[31]), B_eff being the adder's B input.
REQ-021 DONE: assert result_valid and ack of latched id for one cycle; set pointer to the other requester; go IDLE.
REQ-022 Latency: req sampled high in IDLE at edge T -> ack/result_valid high during cycle after edge T+2; throughput one op per 3 cycles.
REQ-023 Requester SHALL drop req in cycle after ack; req still high when FSM re-enters IDLE is a new request.
REQ-024 Operand or req changes while busy SHALL NOT affect the in-flight operation.
REQ-025 A requester losing arbitration SHALL be served in the next IDLE grant if its req is still high (starvation-free, max wait one operation).
REQ-026 Wrap-around: 0xFFFFFFFF+1 SHALL give result 0, carry_out 1, no error state.
REQ-027 ack0 and ack1 SHALL never be high in the same cycle; result_valid SHALL equal ack0|ack1.
REQ-028 result, carry_out, overflow, result_id SHALL hold their values outside DONE until the next DONE.

Reset
REQ-029 reset high at an edge SHALL force IDLE, pointer = 0, operand regs = 0, result = 0, carry_out = 0, overflow = 0, result_id = 0, ack0 = ack1 = result_valid = busy = 0.
REQ-030 reset SHALL override all other inputs in the same cycle, including mid-operation (ADD or DONE); aborted operation SHALL produce no ack.
REQ-031 First grant after reset with both reqs high SHALL go to requester 0.

Verification
REQ-032 req0 only, a0=5, b0=7, sub0=0 -> ack0 two cycles after grant, result=12, carry_out=0, overflow=0, result_id=0.
REQ-033 req1 only, a1=3, b1=5, sub1=1 -> result=0xFFFFFFFE, carry_out=0, overflow=0, result_id=1.
REQ-034 req0, a0=0x7FFFFFFF, b0=1, sub0=0 -> result=0x80000000, overflow=1, carry_out=0; a0=0xFFFFFFFF, b0=1 -> result=0, carry_out=1, overflow=0.
REQ-035 req0 and req1 held continuously after reset -> ack order 0,1,0,1, one ack every 3 cycles, never simultaneous.
REQ-036 reset asserted in ADD state -> next cycle IDLE, busy=0, no ack, all outputs 0; new request afterwards completes normally.
REQ-037 Operands changed during ADD -> result reflects values latched at grant.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester, round-robin arbitrated 32-bit add/subtract unit.
// Every operation is computed by one shared ripple adder.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req0/a0/b0/sub0             requester 0 request, operands, subtract select
//   req1/a1/b1/sub1             requester 1 request, operands, subtract select
//   ack0, ack1                  one-cycle completion pulse to the served requester
//   result, carry_out, overflow registered arithmetic results
//   result_valid, result_id     result strobe and index of the served requester
//   busy                        high while an operation is in flight
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; latches the winner's operands
// ADD     | adder output captured into the result registers
// DONE    | pulses ack/result_valid, advances the priority pointer

module ripple_adder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        carry_in,
  output logic [31:0] S,
  output logic        carry_out
);

  logic [32:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign carry_out = c[32];

endmodule

module adder_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        sub0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        sub1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        overflow,
  output logic        result_valid,
  output logic        result_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        ptr_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sub_q;
  logic        id_q;
  logic [31:0] result_q;
  logic        carry_q;
  logic        ovf_q;
  logic        rid_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        valid_q;
  logic        busy_q;

  logic        grant_d;
  logic [31:0] b_eff;
  logic [31:0] sum;
  logic        sum_co;
  logic        ovf_d;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_d = 1'b0;
    if (req0 && req1) begin
      grant_d = ptr_q;
    end else if (req1) begin
      grant_d = 1'b1;
    end
  end

  // Subtraction as A + ~B + 1, so carry_out = 1 means no borrow.
  assign b_eff = sub_q ? ~b_q : b_q;

  ripple_adder32 u_adder (
    .S         (sum),
    .carry_out (sum_co),
    .A         (a_q),
    .B         (b_eff),
    .carry_in  (sub_q)
  );

  assign ovf_d = (a_q[31] == b_eff[31]) && (sum[31] != a_q[31]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rid_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            a_q     <= grant_d ? a1 : a0;
            b_q     <= grant_d ? b1 : b0;
            sub_q   <= grant_d ? sub1 : sub0;
            id_q    <= grant_d;
            state_q <= ADD;
            busy_q  <= 1'b1;
          end
        end
        ADD: begin
          result_q <= sum;
          carry_q  <= sum_co;
          ovf_q    <= ovf_d;
          rid_q    <= id_q;
          state_q  <= DONE;
        end
        DONE: begin
          // Strobes land in the cycle after this edge, so the requester
          // sees ack while the FSM is already back in IDLE.
          valid_q <= 1'b1;
          ack0_q  <= ~id_q;
          ack1_q  <= id_q;
          ptr_q   <= ~id_q;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign result       = result_q;
  assign carry_out    = carry_q;
  assign overflow     = ovf_q;
  assign result_valid = valid_q;
  assign result_id    = rid_q;
  assign busy         = busy_q;

endmodule
